// File: rtl/sync_pkg.sv
`ifndef SYNC_PKG_SV
`define SYNC_PKG_SV

// Elaboration-time parameter guard: instantiates a named generate block that
// raises an elaboration error when BAD evaluates true.
`define SYNC_PARAM_CHECK(LBL, BAD, MSG) \
    if (BAD) begin : LBL \
        $error(MSG); \
    end

// Shared definitions for the clock-domain-crossing synchroniser family.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package sync_pkg;

    // Fewer than two flops gives no metastability settling time at all.
    localparam int SYNC_MIN_STAGES = 2;

    // Ceiling log2 for sizing counters; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/sync_filter_chan.sv
// One synchroniser channel: flop chain, optional stability filter, edge pulses.
// Latency: NUM_STAGES edges to the output, plus FILTER_CYCLES when filtering.
// Backpressure: none; a free-running sampler that never stalls its input.
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   NUM_STAGES    = 2,
    parameter int   FILTER_CYCLES = 0,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic un_sync,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    `SYNC_PARAM_CHECK(g_chk_stages, NUM_STAGES < SYNC_MIN_STAGES,
                      "sync_filter_chan: NUM_STAGES must be at least 2")

    `SYNC_PARAM_CHECK(g_chk_filter, FILTER_CYCLES < 0,
                      "sync_filter_chan: FILTER_CYCLES must not be negative")

    logic [NUM_STAGES-1:0] stage;
    logic                  chain_out;
    // Value sync_out will hold after the coming edge; drives the pulse flops.
    logic                  sync_nxt;

    assign chain_out = stage[NUM_STAGES-1];

    // Synchroniser chain: stage[0] takes the raw input, each later stage its predecessor.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage <= {NUM_STAGES{RST_VAL}};
        end else begin
            stage <= {stage[NUM_STAGES-2:0], un_sync};
        end
    end

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            // Unfiltered: the output is the chain tail, so the next output is
            // the stage just ahead of it.
            assign sync_out = chain_out;
            assign sync_nxt = stage[NUM_STAGES-2];
        end else begin : g_filter
            localparam int            CNT_W    = clog2(FILTER_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

            logic [CNT_W-1:0] dis_cnt;
            logic             out_q;
            logic             differ;
            logic             accept;

            assign differ   = chain_out ^ out_q;
            // The Fth consecutive disagreeing edge commits the new value.
            assign accept   = differ && (dis_cnt == CNT_LAST);
            assign sync_nxt = accept ? chain_out : out_q;
            assign sync_out = out_q;

            // Disagreement run counter and filtered output bit.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    out_q   <= RST_VAL;
                    dis_cnt <= '0;
                end else begin
                    out_q <= sync_nxt;
                    if (!differ || accept) begin
                        dis_cnt <= '0;
                    end else begin
                        dis_cnt <= dis_cnt + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Edge pulses registered alongside the output so they align with its first new cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= sync_nxt & ~sync_out;
            fall_pulse <= ~sync_nxt & sync_out;
        end
    end

endmodule

// File: rtl/multi_bit_sync_filt.sv
// Multi-channel synchroniser for quasi-static async flags with glitch filter and edge pulses.
// Latency: NUM_STAGES edges (+FILTER_CYCLES when filtering); any_change is comb from pulse flops.
// Backpressure: none; every channel samples its input on every CLK edge.
module multi_bit_sync_filt
    import sync_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               NUM_STAGES    = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] RST_VAL       = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] un_sync_bus,
    output logic [WIDTH-1:0] sync_bus,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    `SYNC_PARAM_CHECK(g_chk_width, WIDTH < 1,
                      "multi_bit_sync_filt: WIDTH must be at least 1")

    `SYNC_PARAM_CHECK(g_chk_stages, NUM_STAGES < SYNC_MIN_STAGES,
                      "multi_bit_sync_filt: NUM_STAGES must be at least 2")

    // Channels are fully independent; one instance per bit.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            sync_filter_chan #(
                .NUM_STAGES    (NUM_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES),
                .RST_VAL       (RST_VAL[i])
            ) u_chan (
                .CLK        (CLK),
                .RST        (RST),
                .un_sync    (un_sync_bus[i]),
                .sync_out   (sync_bus[i]),
                .rise_pulse (rise_pulse[i]),
                .fall_pulse (fall_pulse[i])
            );
        end
    endgenerate

    // Summary flag built from already-registered pulses, so it is glitch-free.
    always_comb begin
        any_change = |{rise_pulse, fall_pulse};
    end

endmodule
